// File: rtl/dataram_arbiter.sv
// Two-requester arbiter in front of a single-port data RAM (CPU port m0, DMA/debug port m1).
// Grants are combinational; read data returns one cycle later, steered by a registered owner tag.
module dataram_arbiter #(
    parameter int FAIR      = 1,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic [13:0] m0_addr,
    input  logic [3:0]  m0_wmask,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [13:0] m1_addr,
    input  logic [3:0]  m1_wmask,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        ram_en,
    output logic [13:0] ram_addr,
    output logic [3:0]  ram_wmask,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int               CNT_W   = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_last_m1;
    logic             r_lock_act;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_rvalid_m0;
    logic             r_rvalid_m1;

    logic             w_m0_gnt;
    logic             w_m1_gnt;
    logic             w_lock_win;
    logic             w_cnt_full;
    logic             w_contend;

    assign w_contend  = m0_req && m1_req;
    assign w_lock_win = r_lock_act && (r_lock_cnt < CNT_MAX);
    assign w_cnt_full = (r_lock_cnt == CNT_MAX);

    // Grant selection: lock first, then the starvation guard, then fairness or fixed priority.
    always_comb begin
        w_m0_gnt = 1'b0;
        w_m1_gnt = 1'b0;
        if (!resetn) begin
            w_m0_gnt = 1'b0;
            w_m1_gnt = 1'b0;
        end else if (w_contend) begin
            if (w_lock_win) begin
                w_m1_gnt = 1'b1;
            end else if (w_cnt_full) begin
                w_m0_gnt = 1'b1;
            end else if (FAIR != 0) begin
                if (r_last_m1) begin
                    w_m0_gnt = 1'b1;
                end else begin
                    w_m1_gnt = 1'b1;
                end
            end else begin
                w_m0_gnt = 1'b1;
            end
        end else begin
            w_m0_gnt = m0_req;
            w_m1_gnt = m1_req;
        end
    end

    // RAM port mux; the byte mask is forced to zero when nobody holds the port.
    always_comb begin
        if (w_m1_gnt) begin
            ram_addr  = m1_addr;
            ram_wmask = m1_wmask;
            ram_wdata = m1_wdata;
        end else if (w_m0_gnt) begin
            ram_addr  = m0_addr;
            ram_wmask = m0_wmask;
            ram_wdata = m0_wdata;
        end else begin
            ram_addr  = m0_addr;
            ram_wmask = 4'b0000;
            ram_wdata = m0_wdata;
        end
    end

    // Arbitration history, lock burst counter and read-owner pipeline.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_m1   <= 1'b1;
            r_lock_act  <= 1'b0;
            r_lock_cnt  <= {CNT_W{1'b0}};
            r_rvalid_m0 <= 1'b0;
            r_rvalid_m1 <= 1'b0;
        end else begin
            if (w_m0_gnt || w_m1_gnt) begin
                r_last_m1 <= w_m1_gnt;
            end
            r_lock_act <= w_m1_gnt && m1_lock;
            // Only a locked m1 grant that overrode a waiting m0 consumes burst budget.
            if (w_m0_gnt || (w_m1_gnt && !m1_lock)) begin
                r_lock_cnt <= {CNT_W{1'b0}};
            end else if (w_m1_gnt && m0_req && r_lock_act && !w_cnt_full) begin
                r_lock_cnt <= r_lock_cnt + CNT_ONE;
            end
            r_rvalid_m0 <= w_m0_gnt && (m0_wmask == 4'b0000);
            r_rvalid_m1 <= w_m1_gnt && (m1_wmask == 4'b0000);
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign ram_en    = w_m0_gnt || w_m1_gnt;
    // Gating with resetn drops a response whose reset arrives in the return cycle.
    assign m0_rvalid = r_rvalid_m0 && resetn;
    assign m1_rvalid = r_rvalid_m1 && resetn;
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Bench for dataram_arbiter: directed scenarios plus random traffic, checked by a grant model,
// a reference memory and a read-return scoreboard.
module tb_dataram_arbiter;

    localparam int BM = 4;

    logic        clk;
    logic        resetn;
    logic        m0_req, m1_req, m1_lock;
    logic [13:0] m0_addr, m1_addr;
    logic [3:0]  m0_wmask, m1_wmask;
    logic [31:0] m0_wdata, m1_wdata;
    logic [31:0] ram_rdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_en;
    logic [31:0] m0_rdata, m1_rdata, ram_wdata;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wmask;

    logic        x_m0_gnt, x_m0_rvalid, x_m1_gnt, x_m1_rvalid, x_ram_en;
    logic [31:0] x_m0_rdata, x_m1_rdata, x_ram_wdata;
    logic [13:0] x_ram_addr;
    logic [3:0]  x_ram_wmask;

    dataram_arbiter #(.FAIR(1), .BURST_MAX(BM)) u_fair (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    dataram_arbiter #(.FAIR(0), .BURST_MAX(BM)) u_fix (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_gnt(x_m0_gnt), .m0_rvalid(x_m0_rvalid), .m0_rdata(x_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(x_m1_gnt), .m1_rvalid(x_m1_rvalid), .m1_rdata(x_m1_rdata),
        .ram_en(x_ram_en), .ram_addr(x_ram_addr), .ram_wmask(x_ram_wmask), .ram_wdata(x_ram_wdata),
        .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic        who;
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] mem[16];
    logic [31:0] ref_mem[16];
    int          m_last[2];
    bit          m_lockp[2];
    int          m_burst[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return 32'h1000_0000 + 32'(a) * 32'h0001_0203;
    endfunction

    // Reference grant rules; k = 0 is the round-robin instance, k = 1 the fixed-priority one.
    function automatic logic [1:0] predict(input int k, input logic r0, input logic r1);
        if (r0 && r1) begin
            if (m_lockp[k] && m_burst[k] < BM) return 2'b10;
            if (m_burst[k] >= BM) return 2'b01;
            if (k == 0) return (m_last[k] == 1) ? 2'b01 : 2'b10;
            return 2'b01;
        end
        if (r0) return 2'b01;
        if (r1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_step(input int k, input logic [1:0] g, input logic r0, input logic lock);
        bit beat_m0;
        beat_m0 = g[1] && r0 && m_lockp[k];
        if (g != 2'b00) m_last[k] = g[1] ? 1 : 0;
        if (g[0] || (g[1] && !lock)) m_burst[k] = 0;
        else if (beat_m0 && m_burst[k] < BM) m_burst[k] = m_burst[k] + 1;
        m_lockp[k] = g[1] && lock;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k]  = 1;
            m_lockp[k] = 1'b0;
            m_burst[k] = 0;
        end
    endtask

    function automatic logic [49:0] bus_of(input logic [1:0] g);
        return g[1] ? {m1_addr, m1_wmask, m1_wdata} : {m0_addr, m0_wmask, m0_wdata};
    endfunction

    // Behavioural single-port RAM attached to the round-robin instance.
    initial begin : ram_model
        for (int i = 0; i < 16; i++) mem[i] = init_val(i);
        ram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_wmask == 4'b0000) begin
                    ram_rdata = mem[ram_addr[3:0]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (ram_wmask[b]) mem[ram_addr[3:0]][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Issue side: predict grants, check the RAM port, push expected read returns.
    initial begin : issue_model
        logic [1:0]  pf, px;
        logic [49:0] bus;
        rd_t         e;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        model_reset();
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("reset_outputs", 64'({m1_gnt, m0_gnt, ram_en, ram_wmask, x_m1_gnt, x_m0_gnt, x_ram_en}), 64'd0);
                model_reset();
                q.delete();
            end else begin
                pf = predict(0, m0_req, m1_req);
                check("gnt", 64'({m1_gnt, m0_gnt}), 64'(pf));
                check("ram_en", 64'(ram_en), 64'(pf != 2'b00));
                if (pf != 2'b00) begin
                    bus = bus_of(pf);
                    check("ram_bus", 64'({ram_addr, ram_wmask, ram_wdata}), 64'(bus));
                    if (bus[35:32] == 4'b0000) begin
                        e.who  = pf[1];
                        e.data = ref_mem[bus[39:36]];
                        e.due  = cyc + 1;
                        q.push_back(e);
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (bus[32+b]) ref_mem[bus[39:36]][8*b +: 8] = bus[8*b +: 8];
                    end
                end else begin
                    check("ram_wmask_idle", 64'(ram_wmask), 64'd0);
                end
                model_step(0, pf, m0_req, m1_lock);
                px = predict(1, m0_req, m1_req);
                check("fixed_gnt", 64'({x_m1_gnt, x_m0_gnt}), 64'(px));
                if (px != 2'b00)
                    check("fixed_ram_bus", 64'({x_ram_en, x_ram_addr, x_ram_wmask, x_ram_wdata}), 64'({1'b1, bus_of(px)}));
                model_step(1, px, m0_req, m1_lock);
            end
        end
    end

    // Return side: every rvalid must match the oldest outstanding read, on time.
    initial begin : rd_monitor
        rd_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("rvalid_in_reset", 64'({m1_rvalid, m0_rvalid}), 64'd0);
            end else if (m0_rvalid || m1_rvalid) begin
                check("rdata_passthru", 64'({m0_rdata ^ ram_rdata, x_m1_rdata ^ ram_rdata}), 64'd0);
                if (q.size() == 0) begin
                    check("rvalid_spurious", 64'({m1_rvalid, m0_rvalid}), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("rvalid_owner", 64'({m1_rvalid, m0_rvalid}), e.who ? 64'd2 : 64'd1);
                    check("rvalid_time", 64'(cyc), 64'(e.due));
                    check("rdata", 64'(e.who ? m1_rdata : m0_rdata), 64'(e.data));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("rvalid_lost", 64'({m1_rvalid, m0_rvalid}), e.who ? 64'd2 : 64'd1);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        logic [31:0] tmp;
        logic [13:0] hist;
        int          n_onehot, n0, n1;
        logic        g0, g1;

        resetn = 1'b0;
        m0_req = 1'b1; m0_addr = 14'd0; m0_wmask = 4'hF; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_addr = 14'd1; m1_wmask = 4'hF; m1_wdata = 32'h0;
        m1_lock = 1'b0;
        repeat (3) next_cycle();

        // Both requesters read after reset: m0 first, then m1, one return per cycle.
        resetn = 1'b1;
        m0_addr = 14'd3; m0_wmask = 4'b0000;
        m1_addr = 14'd7; m1_wmask = 4'b0000;
        @(negedge clk);
        check("t_tie_c0", 64'({m1_gnt, m0_gnt}), 64'd1);
        next_cycle(); m0_req = 1'b0;
        @(negedge clk);
        check("t_tie_c1", 64'({m1_gnt, m0_gnt, m0_rvalid, m1_rvalid}), 64'b1010);
        check("t_tie_d0", 64'(m0_rdata), 64'(init_val(3)));
        next_cycle(); m1_req = 1'b0;
        @(negedge clk);
        check("t_tie_c2", 64'({m0_rvalid, m1_rvalid}), 64'b01);
        check("t_tie_d1", 64'(m1_rdata), 64'(init_val(7)));

        // Partial write by m0 then read-back by m1.
        next_cycle();
        m0_req = 1'b1; m0_addr = 14'd5; m0_wmask = 4'b0011; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t_wr_gnt", 64'({m1_gnt, m0_gnt}), 64'd1);
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 14'd5; m1_wmask = 4'b0000;
        @(negedge clk);
        check("t_wr_rd_gnt", 64'({m1_gnt, m0_gnt, m0_rvalid, m1_rvalid}), 64'b1000);
        next_cycle(); m1_req = 1'b0;
        @(negedge clk);
        tmp = init_val(5);
        check("t_wr_rd_valid", 64'({m0_rvalid, m1_rvalid}), 64'b01);
        check("t_wr_rd_data", 64'(m1_rdata), 64'({tmp[31:16], 16'hBEEF}));

        // Locked m1 burst against a continuously waiting m0.
        next_cycle();
        m0_req = 1'b1; m0_addr = 14'd1; m0_wmask = 4'b0000;
        m1_req = 1'b1; m1_addr = 14'd2; m1_wmask = 4'b0000; m1_lock = 1'b1;
        hist = 14'd0; n_onehot = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            hist[i] = m1_gnt;
            if (m0_gnt ^ m1_gnt) n_onehot++;
            next_cycle();
        end
        check("t_lock_seq", 64'(hist), 64'(14'b10111110111110));
        check("t_lock_onehot", 64'(n_onehot), 64'd14);

        // Fixed-priority instance with both requesting and no lock.
        m1_lock = 1'b0; n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (x_m0_gnt) n0++;
            if (x_m1_gnt) n1++;
            next_cycle();
        end
        check("t_fixed_m0", 64'(n0), 64'd6);
        check("t_fixed_m1", 64'(n1), 64'd0);

        // Reset arriving in the return cycle of a read.
        m0_req = 1'b0; m1_req = 1'b0;
        next_cycle();
        m0_req = 1'b1; m0_addr = 14'd9; m0_wmask = 4'b0000;
        @(negedge clk);
        check("t_rst_gnt", 64'({m1_gnt, m0_gnt}), 64'd1);
        next_cycle(); m0_req = 1'b0; resetn = 1'b0;
        @(negedge clk);
        check("t_rst_rv_a", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t_rst_rv_b", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        next_cycle();
        resetn = 1'b1;
        m0_req = 1'b1; m0_addr = 14'd4;
        m1_req = 1'b1; m1_addr = 14'd6; m1_wmask = 4'b0000;
        @(negedge clk);
        check("t_rst_first", 64'({m1_gnt, m0_gnt}), 64'd1);
        next_cycle(); m0_req = 1'b0;
        next_cycle(); m1_req = 1'b0;

        // Random traffic; requests are held until granted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            next_cycle();
            if (!m0_req || g0) begin
                m0_req   = ($urandom_range(0, 99) < 60);
                m0_addr  = 14'($urandom_range(0, 15));
                m0_wmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                m0_wdata = $urandom;
            end
            if (!m1_req || g1) begin
                m1_req   = ($urandom_range(0, 99) < 60);
                m1_addr  = 14'($urandom_range(0, 15));
                m1_wmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                m1_wdata = $urandom;
            end
            m1_lock = ($urandom_range(0, 99) < 70);
        end

        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("drain_queue", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dataram_arbiter.md
DATARAM_ARBITER -- requirements
Module: dataram_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin on contention, 0 = fixed priority to m0.
REQ-002 Parameter BURST_MAX, default 4: maximum consecutive locked m1 grants while m0 is waiting.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 m0_req  input  1  requester 0 (CPU load/store stage) access request.
REQ-006 m0_addr  input  14  requester 0 word address.
REQ-007 m0_wmask  input  4  requester 0 byte write mask; 4'b0000 = read.
REQ-008 m0_wdata  input  32  requester 0 write data, byte lanes pre-aligned.
REQ-009 m0_gnt  output  1  requester 0 access accepted this cycle.
REQ-010 m0_rvalid  output  1  requester 0 read data valid.
REQ-011 m0_rdata  output  32  requester 0 read data.
REQ-012 m1_req, m1_addr[13:0], m1_wmask[3:0], m1_wdata[31:0] (inputs) and m1_gnt, m1_rvalid, m1_rdata[31:0] (outputs) behave as the m0 signals, for requester 1 (DMA/debug loader).
REQ-013 m1_lock  input  1  requester 1 asks to keep the port for its next request.
REQ-014 ram_en  output  1  RAM access strobe.
REQ-015 ram_addr  output  14  RAM word address.
REQ-016 ram_wmask  output  4  RAM byte write enables.
REQ-017 ram_wdata  output  32  RAM write data.
REQ-018 ram_rdata  input  32  RAM read data, valid the cycle after a read strobe.

Function
REQ-019 Grant is combinational: mN_gnt SHALL assert in the same cycle as mN_req when requester N is selected; at most one gnt high per cycle.
REQ-020 A requester SHALL hold req, addr, wmask and wdata stable until gnt; a grant completes the transfer, and write completion is signalled by gnt alone.
REQ-021 ram_en SHALL equal (m0_gnt | m1_gnt); ram_addr, ram_wmask and ram_wdata SHALL come from the granted requester; ram_wmask SHALL be 0 whenever ram_en is low.
REQ-022 Single requester: it SHALL be granted unconditionally, except during reset.
REQ-023 Contention with FAIR=1: grant the requester not granted most recently (last_gnt register, updated on every grant).
REQ-024 Contention with FAIR=0: grant m0, except under REQ-025.
REQ-025 Lock: if m1 was granted last cycle with m1_lock=1, m1 is requesting now, and lock_cnt < BURST_MAX, then m1 SHALL win contention.
REQ-026 lock_cnt SHALL increment on each locked m1 grant that beats a waiting m0 request, and SHALL clear when m0 is granted or when m1 is granted with m1_lock=0.
REQ-027 When lock_cnt == BURST_MAX and m0 is requesting, m0 SHALL be granted (starvation guard).
REQ-028 lock_cnt width SHALL be clog2(BURST_MAX+1); it SHALL saturate and never wrap.
REQ-029 Read return: one cycle after a read grant (wmask 0), the granted requester's rvalid SHALL be 1 for exactly one cycle and its rdata SHALL equal ram_rdata; the other requester's rvalid SHALL stay 0.
REQ-030 Back-to-back reads, including alternating requesters, SHALL sustain one access per cycle, with each rvalid routed by a registered read-owner tag.
REQ-031 A write grant SHALL never produce rvalid.
REQ-032 mN_rdata SHALL be driven from ram_rdata at all times and is meaningful only when mN_rvalid is 1.

Reset
REQ-033 While resetn=0: m0_gnt, m1_gnt, ram_en and ram_wmask SHALL be 0, whatever the request inputs.
REQ-034 Reset state: last_gnt = m1 (so m0 wins the first tie), lock_cnt = 0, lock-active flag = 0, read-owner/rvalid pipeline cleared.
REQ-035 Reset during a read: the cycle after resetn is sampled low, both rvalid SHALL be 0; an access in flight is dropped with no response.

Verification
REQ-036 Both req high, read, FAIR=1, after reset -> cycle0 m0_gnt; cycle1 m1_gnt and m0_rvalid with RAM[m0_addr]; cycle2 m1_rvalid.
REQ-037 m0 writes 0xDEADBEEF with wmask 4'b0011 to address 5, then m1 reads address 5 -> m1_rdata = {old[31:16],16'hBEEF}, one cycle after m1_gnt.
REQ-038 m1_lock=1 with continuous m1_req and m0_req, BURST_MAX=4 -> after m1 holds the port, m1 wins 4 locked contended grants, then m0 is granted, then lock_cnt is 0.
REQ-039 FAIR=0, both requesting continuously, m1_lock=0 -> m0 granted every cycle, m1_gnt stays 0.
REQ-040 Read granted, resetn pulled low next cycle -> no rvalid; after release, the first contended request goes to m0.
REQ-041 Random requests with a reference memory model -> never two gnts, no lost or duplicated rvalid, all read data matches.
